// File: rtl/mat_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mat_ctrl_pkg
// Brief   : Shared state encodings and width helpers for the layer sequencer.
// Revision: 1.0
// ============================================================================
package mat_ctrl_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  // Tag word = {valid, out_addr}; this is the width of the control part.
  localparam int TAG_CTRL_W = 1;

  // Address width for a memory of n words; never returns zero.
  function automatic int addr_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int tag_w(input int out_aw);
    return out_aw + TAG_CTRL_W;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mat_tag_pipe.sv
`default_nettype none
// ============================================================================
// Module  : mat_tag_pipe
// Brief   : Fixed-depth, non-stalling shift register of result tags.
// Revision: 1.0
// ============================================================================
module mat_tag_pipe #(
  parameter int DEPTH = 2,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] tag_i,
  output logic [W-1:0] tag_o
);

  logic [W-1:0] stage_q [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= tag_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign tag_o = stage_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/mat_layer_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : mat_layer_ctrl
// Brief   : Sequencer for the 8-filter MAC array: walks filter groups, pixels
//           and input-channel groups, drives RAM addresses, load and results.
//           Optional MAT_CTRL_PERF_EN adds a busy-cycle counter (perf_cycles).
// Revision: 1.0
// ============================================================================
module mat_layer_ctrl
  import mat_ctrl_pkg::*;
#(
  parameter int NUM_PIX  = 64,
  parameter int CIN_GRP  = 2,
  parameter int COUT_GRP = 2,
  parameter int PIPE_LAT = 4,
  parameter int RD_LAT   = 1,
  localparam int DAW = addr_w(NUM_PIX * CIN_GRP),
  localparam int WAW = addr_w(COUT_GRP * CIN_GRP),
  localparam int BAW = addr_w(COUT_GRP),
  localparam int OAW = addr_w(NUM_PIX * COUT_GRP)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  output logic           busy,
  output logic           done,
  output logic [DAW-1:0] data_addr,
  output logic [WAW-1:0] wgt_addr,
  output logic [BAW-1:0] bias_addr,
  output logic           load,
  output logic           out_valid,
  output logic [OAW-1:0] out_addr
`ifdef MAT_CTRL_PERF_EN
  ,
  output logic [31:0]    perf_cycles
`endif
);

  localparam int CW    = addr_w(CIN_GRP);
  localparam int PW    = addr_w(NUM_PIX);
  localparam int GW    = addr_w(COUT_GRP);
  localparam int DEPTH = RD_LAT + PIPE_LAT;
  localparam int LW    = addr_w(DEPTH + 1);
  localparam int TW    = tag_w(OAW);

  if (RD_LAT != 1 || PIPE_LAT < 1) begin : g_param_chk
    $error("mat_layer_ctrl: RD_LAT must be 1 and PIPE_LAT >= 1");
  end

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] c_q, c_d;
  logic [PW-1:0] p_q, p_d;
  logic [GW-1:0] g_q, g_d;
  logic [LW-1:0] drain_q, drain_d;
  logic          load_q;

  logic          w_issue, w_c_last, w_p_last, w_g_last;
  logic [OAW-1:0] w_tag_addr;
  logic [TW-1:0]  w_tag_in, w_tag_out;

  assign w_issue  = (state_q == RUN);
  assign w_c_last = (c_q == CW'(CIN_GRP - 1));
  assign w_p_last = (p_q == PW'(NUM_PIX - 1));
  assign w_g_last = (g_q == GW'(COUT_GRP - 1));

  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    p_d     = p_q;
    g_d     = g_q;
    drain_d = drain_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          c_d     = '0;
          p_d     = '0;
          g_d     = '0;
        end
      end
      RUN: begin
        // Counters freeze on the final issue so addresses hold through drain.
        if (w_c_last && w_p_last && w_g_last) begin
          state_d = DRAIN;
          drain_d = LW'(1);
        end else if (!w_c_last) begin
          c_d = c_q + 1'b1;
        end else begin
          c_d = '0;
          if (!w_p_last) begin
            p_d = p_q + 1'b1;
          end else begin
            p_d = '0;
            g_d = g_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (drain_q == LW'(DEPTH)) state_d = DONE;
        else                       drain_d = drain_q + 1'b1;
      end
      DONE: begin
        state_d = IDLE;
        c_d     = '0;
        p_d     = '0;
        g_d     = '0;
        drain_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      c_q     <= '0;
      p_q     <= '0;
      g_q     <= '0;
      drain_q <= '0;
      load_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      p_q     <= p_d;
      g_q     <= g_d;
      drain_q <= drain_d;
      load_q  <= w_issue && (c_q == '0);
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign load      = load_q;
  assign data_addr = DAW'(32'(p_q) * CIN_GRP + 32'(c_q));
  assign wgt_addr  = WAW'(32'(g_q) * CIN_GRP + 32'(c_q));
  assign bias_addr = BAW'(g_q);

  assign w_tag_addr = OAW'(32'(g_q) * NUM_PIX + 32'(p_q));
  assign w_tag_in   = {w_issue && w_c_last, w_tag_addr};

  mat_tag_pipe #(
    .DEPTH (DEPTH),
    .W     (TW)
  ) u_tag_pipe (
    .clk   (clk),
    .rst   (rst),
    .tag_i (w_tag_in),
    .tag_o (w_tag_out)
  );

  assign out_valid = w_tag_out[TW-1];
  assign out_addr  = w_tag_out[OAW-1:0];

`ifdef MAT_CTRL_PERF_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_q <= '0;
    end else if (state_q == IDLE && start) begin
      perf_q <= '0;
    end else if (state_q != IDLE && perf_q != '1) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_cycles = perf_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mat_layer_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_mat_layer_ctrl
// Brief   : Scoreboard bench for mat_layer_ctrl (NUM_PIX=4, CIN=2, COUT=2, LAT=3).
// Revision: 1.0
// ============================================================================
module tb_mat_layer_ctrl;

  localparam int NP = 4;
  localparam int CG = 2;
  localparam int GG = 2;
  localparam int PL = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       busy, done, load, out_valid;
  logic [2:0] data_addr;
  logic [1:0] wgt_addr;
  logic [0:0] bias_addr;
  logic [2:0] out_addr;
`ifdef MAT_CTRL_PERF_EN
  logic [31:0] perf_cycles;
`endif

  mat_layer_ctrl #(
    .NUM_PIX  (NP),
    .CIN_GRP  (CG),
    .COUT_GRP (GG),
    .PIPE_LAT (PL),
    .RD_LAT   (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .data_addr (data_addr),
    .wgt_addr  (wgt_addr),
    .bias_addr (bias_addr),
    .load      (load),
    .out_valid (out_valid),
    .out_addr  (out_addr)
`ifdef MAT_CTRL_PERF_EN
    ,
    .perf_cycles (perf_cycles)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int addr;
  } exp_t;

  exp_t sbq[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string nm, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0d expected=%0d", nm, cyc, act, exp_v);
    end
  endtask

  // Monitor: every presented result must match the next expected entry.
  initial begin
    forever begin
      @(negedge clk);
      if (out_valid !== 1'b0) begin
        if (sbq.size() == 0) begin
          chk("out_valid_unexpected", 1, 0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("out_cycle", cyc, e.cyc);
          chk("out_addr", int'(out_addr), e.addr);
        end
      end
    end
  end

  task automatic zero_chk(input string tag);
    chk({tag, "_busy"},  int'(busy), 0);
    chk({tag, "_done"},  int'(done), 0);
    chk({tag, "_load"},  int'(load), 0);
    chk({tag, "_data"},  int'(data_addr), 0);
    chk({tag, "_wgt"},   int'(wgt_addr), 0);
    chk({tag, "_bias"},  int'(bias_addr), 0);
    chk({tag, "_oval"},  int'(out_valid), 0);
  endtask

  // Expected values for cycle k after the start cycle (k=0).
  task automatic cycle_chk(input int k);
    int i;
    int e_data, e_wgt, e_bias;
    i = k - 1;
    if (k >= 1 && k <= 16) begin
      e_data = i % 8;
      e_wgt  = (i / 8) * 2 + (i % 2);
      e_bias = i / 8;
    end else if (k >= 17 && k <= 21) begin
      e_data = 7;
      e_wgt  = 3;
      e_bias = 1;
    end else begin
      e_data = 0;
      e_wgt  = 0;
      e_bias = 0;
    end
    chk("busy", int'(busy), (k >= 1 && k <= 21) ? 1 : 0);
    chk("done", int'(done), (k == 21) ? 1 : 0);
    chk("data_addr", int'(data_addr), e_data);
    chk("wgt_addr", int'(wgt_addr), e_wgt);
    chk("bias_addr", int'(bias_addr), e_bias);
    chk("load", int'(load), (k >= 2 && k <= 16 && (k % 2) == 0) ? 1 : 0);
  endtask

  task automatic begin_layer();
    int t0;
    @(negedge clk);
    start = 1'b1;
    t0    = cyc;
    for (int j = 0; j < NP * GG; j++) begin
      exp_t e;
      e.cyc  = t0 + 6 + 2 * j;
      e.addr = j;
      sbq.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_layer(input int restart_at);
    begin_layer();
    for (int k = 1; k <= 23; k++) begin
      cycle_chk(k);
`ifdef MAT_CTRL_PERF_EN
      if (k == 22) chk("perf_cycles", int'(perf_cycles), 21);
`endif
      start = (k == restart_at) ? 1'b1 : 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    chk("sb_drained", sbq.size(), 0);
  endtask

  task automatic reset_mid_layer();
    begin_layer();
    for (int k = 1; k <= 8; k++) begin
      cycle_chk(k);
      @(negedge clk);
    end
    rst = 1'b1;
    sbq.delete();
    #1;
    zero_chk("rst_c9");
    @(negedge clk);
    zero_chk("rst_c10");
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      zero_chk("post_rst");
      @(negedge clk);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cycle=%0d actual=timeout expected=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    zero_chk("reset");
    rst = 1'b0;
    @(negedge clk);
    zero_chk("idle");

    run_layer(0);
    run_layer(5);
    reset_mid_layer();
    run_layer(0);

    repeat (2) @(negedge clk);
    chk("sb_empty", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
